// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port, byte-addressed, 64-bit big-endian data memory
//   between the pipeline MEM stage (port p) and an auxiliary loader/debug
//   port (port a). The pipeline has priority; a starvation counter forces
//   an aux grant after MAX_WAIT lost cycles. Out-of-range accesses are
//   consumed without a memory strobe and answered with an err pulse and
//   zero read data.
//
//   Build option: define DMEM_ALIGN_CHECK_EN to additionally reject
//   accesses whose address is not doubleword aligned (addr[2:0] != 0).
//   Without it, unaligned accesses touch bytes addr..addr+7 and are
//   subject only to the range check.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,    // legal 1..15
  parameter int unsigned DEPTH    = 226   // memory size in bytes
) (
  input  logic        clock,
  input  logic        reset_n,
  // pipeline MEM stage
  input  logic        p_req,
  input  logic        p_we,
  input  logic [7:0]  p_addr,
  input  logic [63:0] p_wdata,
  output logic        p_stall,
  output logic [63:0] p_rdata,
  output logic        p_rvalid,
  // auxiliary loader/debug port
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [63:0] a_wdata,
  output logic        a_gnt,
  output logic [63:0] a_rdata,
  output logic        a_rvalid,
  // data memory
  output logic [7:0]  mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_rdata,
  // error report
  output logic        err
);

  // Highest start address whose eight bytes all fall inside the memory.
  localparam logic [7:0] LAST_ADDR_C = 8'(DEPTH - 8);
  localparam logic [3:0] MAX_WAIT_C  = 4'(MAX_WAIT);

  // Legality check for a doubleword access starting at addr.
  function automatic logic addr_legal(input logic [7:0] addr);
    logic ok;
    ok = (addr <= LAST_ADDR_C);
`ifdef DMEM_ALIGN_CHECK_EN
    ok = ok && (addr[2:0] == 3'b000);
`endif
    return ok;
  endfunction

  // ------------------------------------------------------------------
  // Internal signals
  // ------------------------------------------------------------------
  logic [3:0]  wait_cnt_r;
  logic        p_gnt_s;
  logic        a_gnt_s;
  logic        any_gnt_s;
  logic        win_we_s;
  logic [7:0]  win_addr_s;
  logic [63:0] win_wdata_s;
  logic        win_legal_s;
  logic        forced_s;

  logic [63:0] p_rdata_r;
  logic        p_rvalid_r;
  logic [63:0] a_rdata_r;
  logic        a_rvalid_r;
  logic        err_r;

  // Starvation condition: aux has lost MAX_WAIT consecutive cycles.
  assign forced_s = (wait_cnt_r == MAX_WAIT_C);

  // Grant decision: at most one winner; nothing is granted while in reset.
  always_comb begin
    p_gnt_s = 1'b0;
    a_gnt_s = 1'b0;
    if (!reset_n) begin
      p_gnt_s = 1'b0;
      a_gnt_s = 1'b0;
    end else if (a_req && (!p_req || forced_s)) begin
      a_gnt_s = 1'b1;
    end else if (p_req) begin
      p_gnt_s = 1'b1;
    end else begin
      p_gnt_s = 1'b0;
      a_gnt_s = 1'b0;
    end
  end

  assign any_gnt_s = p_gnt_s | a_gnt_s;

  // Route the winner's request onto the memory bus; idle bus is all zero.
  always_comb begin
    win_we_s    = 1'b0;
    win_addr_s  = 8'h00;
    win_wdata_s = 64'h0;
    case ({a_gnt_s, p_gnt_s})
      2'b10: begin
        win_we_s    = a_we;
        win_addr_s  = a_addr;
        win_wdata_s = a_wdata;
      end
      2'b01: begin
        win_we_s    = p_we;
        win_addr_s  = p_addr;
        win_wdata_s = p_wdata;
      end
      default: begin
        win_we_s    = 1'b0;
        win_addr_s  = 8'h00;
        win_wdata_s = 64'h0;
      end
    endcase
  end

  assign win_legal_s = any_gnt_s && addr_legal(win_addr_s);

  assign mem_addr  = win_addr_s;
  assign mem_wdata = win_wdata_s;
  // Strobes only for a legal access by an actual winner.
  assign mem_write = win_legal_s &&  win_we_s;
  assign mem_read  = win_legal_s && !win_we_s;

  // Pipeline stalls only when it asks and aux was forced in ahead of it.
  assign p_stall = reset_n && p_req && !p_gnt_s;
  assign a_gnt   = a_gnt_s;

  // Starvation counter: counts aux cycles lost, saturating at MAX_WAIT.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_r <= 4'd0;
    end else if (a_req && !a_gnt_s) begin
      if (!forced_s) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= 4'd0;
    end
  end

  // Completion pulses and error flag for the access granted this cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_rvalid_r <= 1'b0;
      a_rvalid_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      p_rvalid_r <= p_gnt_s;
      a_rvalid_r <= a_gnt_s;
      err_r      <= any_gnt_s && !win_legal_s;
    end
  end

  // Pipeline read data: loaded on a legal read, zeroed on a rejected access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_rdata_r <= 64'h0;
    end else if (p_gnt_s) begin
      if (!win_legal_s) begin
        p_rdata_r <= 64'h0;
      end else if (!win_we_s) begin
        p_rdata_r <= mem_rdata;
      end else begin
        p_rdata_r <= p_rdata_r;
      end
    end else begin
      p_rdata_r <= p_rdata_r;
    end
  end

  // Aux read data: loaded on a legal read, zeroed on a rejected access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_r <= 64'h0;
    end else if (a_gnt_s) begin
      if (!win_legal_s) begin
        a_rdata_r <= 64'h0;
      end else if (!win_we_s) begin
        a_rdata_r <= mem_rdata;
      end else begin
        a_rdata_r <= a_rdata_r;
      end
    end else begin
      a_rdata_r <= a_rdata_r;
    end
  end

  assign p_rdata  = p_rdata_r;
  assign p_rvalid = p_rvalid_r;
  assign a_rdata  = a_rdata_r;
  assign a_rvalid = a_rvalid_r;
  assign err      = err_r;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, byte-addressed, 64-bit big-endian data memory between two requesters:
  - the pipeline MEM stage (port p);
  - an auxiliary loader/debug port (port a).
- The pipeline has priority. A starvation counter forces an aux grant after MAX_WAIT lost cycles.
- Sits between the MEM stage and data memory; drives the memory's Address/WriteData/MemRead/MemWrite.
- Registers read data into per-port responses and rejects out-of-range accesses.

Parameters:
- MAX_WAIT, 4, cycles aux may lose arbitration before a forced grant (legal 1..15).
- DEPTH, 226, memory size in bytes; a legal access needs addr <= DEPTH-8.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- p_req  in  1  pipeline access request, valid for the current cycle.
- p_we  in  1  1=store doubleword, 0=load doubleword.
- p_addr  in  8  pipeline byte address.
- p_wdata  in  64  pipeline store data.
- p_stall  out  1  combinational; p_req high but not granted this cycle.
- p_rdata  out  64  registered load data.
- p_rvalid  out  1  one-cycle pulse, cycle after a granted pipeline access.
- a_req  in  1  aux request; held with stable a_we/a_addr/a_wdata until a_gnt.
- a_we  in  1  aux write enable.
- a_addr  in  8  aux byte address.
- a_wdata  in  64  aux write data.
- a_gnt  out  1  combinational; aux access performed this cycle.
- a_rdata  out  64  registered aux read data.
- a_rvalid  out  1  one-cycle pulse, cycle after an aux grant.
- mem_addr  out  8  to memory Address.
- mem_wdata  out  64  to memory WriteData.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_rdata  in  64  from memory ReadData (combinational read).
- err  out  1  registered one-cycle pulse on a rejected access.

Behaviour:
- Reset (reset_n low, async):
  - wait_cnt, p_rvalid, a_rvalid, err are cleared to 0.
  - p_rdata and a_rdata are cleared to 64'h0.
  - mem_read, mem_write, p_stall and a_gnt are forced to 0 while reset is held.
- Grant decision, combinational, exactly one or zero winners per cycle:
  - aux wins if a_req && (!p_req || wait_cnt == MAX_WAIT);
  - else pipeline wins if p_req.
- The winner's addr/wdata drive mem_addr/mem_wdata. When idle, mem_addr and mem_wdata are 0.
- mem_write = winner_we && legal; mem_read = !winner_we && legal.
- Legal means addr <= DEPTH-8 (218 by default). 8-bit address arithmetic never wraps inside the memory.
- Write timing: memory commits the write at the rising edge that ends the grant cycle.
- Read timing: mem_rdata is captured into the winner's rdata at that same edge. The winner's rvalid is high for the next cycle only. Load-use latency is 1 cycle.
- Writes also pulse rvalid (acts as the completion ack); rdata is unchanged on a write.
- Illegal access:
  - no mem strobe;
  - the request is still consumed (grant, no stall);
  - next cycle: err=1, winner rvalid=1, winner rdata=64'h0.
- wait_cnt (4 bits):
  - increments each cycle a_req && !a_gnt;
  - clears on a_gnt or when a_req is low;
  - saturates at MAX_WAIT.
- When forced: p_stall=1 for exactly that cycle. The pipeline must hold its request; it is granted the following cycle.
- Simultaneous p/a requests to the same address: ordering follows grant order only; no forwarding.
- a_req dropped before a_gnt: the request is abandoned and the counter clears.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: addr[2:0] != 0 is also illegal (no strobe, err pulse, rdata 0).
- Undefined: unaligned accesses are allowed and read/write bytes addr..addr+7, subject only to the range check.

Test Plan:
- p_req read, addr 8, no aux -> p_stall=0, mem_read=1, mem_addr=8; next cycle p_rvalid=1, p_rdata=64'h1111111111111111.
- a_req and p_req both held high, MAX_WAIT=4:
  - pipeline granted 4 cycles;
  - cycle 5: a_gnt=1, p_stall=1;
  - cycle 6: pipeline granted, wait_cnt=0.
- Aux write 64'h0123456789ABCDEF to addr 16, then pipeline read addr 16 -> p_rdata=64'h0123456789ABCDEF.
- Pipeline read addr 220 -> mem_read=0, mem_write=0; next cycle err=1, p_rvalid=1, p_rdata=0; no stall.
- reset_n pulsed low with wait_cnt=3 and p_rvalid=1 -> both cleared immediately (no clock edge); after release, aux loses 4 more cycles before a forced grant.
- Read addr 9:
  - macro defined -> err=1, p_rdata=0;
  - macro undefined -> bytes 9..16, p_rdata=64'h1111111111111122.
